alu_shift_pipe: RTL and testbench

Parametrised, pipelined barrel shifter that replaces the single-cycle combinational shift unit in the ALU execute path. It performs logical left/right, arithmetic right and (optionally) rotate operations on a `DATA_WIDTH` operand, by an amount taken from Rs2 or an immediate. Operations pass through `PIPE_STAGES` register stages under a valid/ready handshake, and a tag rides alongside for writeback matching.

---
 rtl/alu_shift_pipe.sv | 165 ++++++++++++++++
 tb/tb_alu_shift_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA, optional ROL/ROR) with a global-stall valid/ready pipe.
// Define ALU_SHIFT_ROTATE_EN to build the rotate ops; otherwise 011/100 decode as illegal.
module alu_shift_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int PIPE_STAGES = 2,
  parameter int IMM_WIDTH   = 6,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2:0]            op_i,
  input  logic                  use_imm_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [IMM_WIDTH-1:0]  imm_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic                  zero_o,
  output logic                  illegal_o
);
  localparam int SHAMT_W  = $clog2(DATA_WIDTH);
  localparam int LVL_BASE = SHAMT_W / PIPE_STAGES;
  localparam int LVL_XTRA = SHAMT_W % PIPE_STAGES;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
`ifdef ALU_SHIFT_ROTATE_EN
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
`endif

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [2:0]            op;
    logic                  fill;
    logic [SHAMT_W-1:0]    amt;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  ill;
  } slot_t;

  // Shift levels owned by stage s; earlier stages absorb the remainder.
  function automatic logic [SHAMT_W-1:0] lvl_mask(input int s);
    int lo;
    int n;
    lo = s * LVL_BASE + ((s < LVL_XTRA) ? s : LVL_XTRA);
    n  = LVL_BASE + ((s < LVL_XTRA) ? 1 : 0);
    lvl_mask = '0;
    for (int b = 0; b < SHAMT_W; b++) lvl_mask[b] = (b >= lo) && (b < lo + n);
  endfunction

  logic                   advance;
  logic                   legal;
  logic [SHAMT_W-1:0]     amt_in;
  slot_t                  entry;
  slot_t                  stg_in  [PIPE_STAGES];
  slot_t                  stg_out [PIPE_STAGES];
  slot_t                  slot_q  [PIPE_STAGES];
  logic [DATA_WIDTH-1:0]  stg_res [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] vld_q;
  logic [PIPE_STAGES:0]   vld_pipe;
  logic                   unused_bits;

  assign vld_pipe   = {vld_q, in_valid_i};
  assign advance    = !out_valid_o || out_ready_i;
  assign in_ready_o = advance;

  // Illegal ops enter as a zero operand under SLL so every level passes zero through.
  always_comb begin
    legal = (op_i == OP_SLL) || (op_i == OP_SRL) || (op_i == OP_SRA);
`ifdef ALU_SHIFT_ROTATE_EN
    if ((op_i == OP_ROL) || (op_i == OP_ROR)) legal = 1'b1;
`endif
    amt_in    = use_imm_i ? imm_i[SHAMT_W-1:0] : rs2_data_i[SHAMT_W-1:0];
    entry     = '0;
    entry.tag = tag_i;
    entry.ill = !legal;
    if (legal) begin
      entry.data = rs1_data_i;
      entry.op   = op_i;
      entry.fill = (op_i == OP_SRA) && rs1_data_i[DATA_WIDTH-1];
      entry.amt  = amt_in;
    end
  end

  always_comb begin
    stg_in[0] = entry;
    for (int s = 1; s < PIPE_STAGES; s++) stg_in[s] = slot_q[s-1];
    for (int s = 0; s < PIPE_STAGES; s++) begin
      stg_out[s]      = stg_in[s];
      stg_out[s].data = stg_res[s];
    end
  end

  for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
    alu_shift_lvl #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHAMT_W    (SHAMT_W),
      .LVL_MASK   (lvl_mask(g))
    ) u_lvl (
      .op_i   (stg_in[g].op),
      .fill_i (stg_in[g].fill),
      .amt_i  (stg_in[g].amt),
      .data_i (stg_in[g].data),
      .data_o (stg_res[g])
    );
  end

  // Payload only loads behind a valid bit; bubbles leave the old contents in place.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      vld_q <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) slot_q[s] <= '0;
    end else if (advance) begin
      vld_q <= vld_pipe[PIPE_STAGES-1:0];
      for (int s = 0; s < PIPE_STAGES; s++)
        if (vld_pipe[s]) slot_q[s] <= stg_out[s];
    end
  end

  assign out_valid_o = vld_q[PIPE_STAGES-1];
  assign result_o    = slot_q[PIPE_STAGES-1].data;
  assign tag_o       = slot_q[PIPE_STAGES-1].tag;
  assign illegal_o   = slot_q[PIPE_STAGES-1].ill;
  assign zero_o      = out_valid_o && (result_o == '0);

  // Upper amount bits are architecturally ignored; last-stage control has no consumer.
  assign unused_bits = ^{rs2_data_i, imm_i, slot_q[PIPE_STAGES-1].op,
                         slot_q[PIPE_STAGES-1].fill, slot_q[PIPE_STAGES-1].amt};
endmodule

// One pipeline stage's share of the log shifter: shifts by the amount bits in LVL_MASK.
module alu_shift_lvl #(
  parameter int                 DATA_WIDTH = 32,
  parameter int                 SHAMT_W    = 5,
  parameter logic [SHAMT_W-1:0] LVL_MASK   = '1
) (
  input  logic [2:0]            op_i,
  input  logic                  fill_i,
  input  logic [SHAMT_W-1:0]    amt_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic [SHAMT_W-1:0] amt_s;

  assign amt_s = amt_i & LVL_MASK;

  always_comb begin
    data_o = data_i;
    case (op_i)
      3'b000:         data_o = data_i << amt_s;
      3'b001, 3'b010: data_o = DATA_WIDTH'({{DATA_WIDTH{fill_i}}, data_i} >> amt_s);
`ifdef ALU_SHIFT_ROTATE_EN
      3'b011:         data_o = DATA_WIDTH'(({data_i, data_i} << amt_s) >> DATA_WIDTH);
      3'b100:         data_o = DATA_WIDTH'({data_i, data_i} >> amt_s);
`endif
      default:        data_o = data_i;
    endcase
  end
endmodule

// File: tb/tb_alu_shift_pipe.sv
// Directed bench for alu_shift_pipe with an occupancy/queue reference model checked every cycle.
module tb_alu_shift_pipe;
  localparam int DW = 32;
  localparam int PS = 2;

  logic          clk_i = 1'b0;
  logic          arst_ni = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [2:0]    op_i = 3'd0;
  logic          use_imm_i = 1'b0;
  logic [DW-1:0] rs1_data_i = '0;
  logic [DW-1:0] rs2_data_i = '0;
  logic [5:0]    imm_i = '0;
  logic [3:0]    tag_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [DW-1:0] result_o;
  logic [3:0]    tag_o;
  logic          zero_o;
  logic          illegal_o;

  always #5 clk_i = ~clk_i;

  alu_shift_pipe #(.DATA_WIDTH(DW), .PIPE_STAGES(PS), .IMM_WIDTH(6), .TAG_WIDTH(4)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .use_imm_i(use_imm_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .imm_i(imm_i), .tag_i(tag_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .tag_o(tag_o), .zero_o(zero_o), .illegal_o(illegal_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {illegal, result} from plain shift arithmetic.
  function automatic logic [32:0] ref_op(input logic [2:0] op, input logic [31:0] x, input int unsigned a);
    logic [31:0] r;
    case (op)
      3'd0: r = x << a;
      3'd1: r = x >> a;
      3'd2: r = $signed(x) >>> a;
`ifdef ALU_SHIFT_ROTATE_EN
      3'd3: r = (a == 0) ? x : ((x << a) | (x >> (32 - a)));
      3'd4: r = (a == 0) ? x : ((x >> a) | (x << (32 - a)));
`endif
      default: return {1'b1, 32'h0};
    endcase
    return {1'b0, r};
  endfunction

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        ill;
    int          cnt;
  } item_t;
  item_t mq[$];
  logic [3:0] tag_log[$];

  // Model: an op reaches the output after PS advancing edges; the output slot drains only when ready.
  bit          m_head;
  int unsigned m_amt;
  logic [32:0] m_r;
  item_t       m_new;
  always @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      mq.delete();
    end else begin
      m_head = (mq.size() > 0) && (mq[0].cnt == PS);
      if (!m_head || out_ready_i) begin
        if (m_head) void'(mq.pop_front());
        foreach (mq[i]) mq[i].cnt++;
        if (in_valid_i) begin
          m_amt = use_imm_i ? (32'(imm_i) % 32) : (rs2_data_i % 32);
          m_r = ref_op(op_i, rs1_data_i, m_amt);
          m_new.res = m_r[31:0];
          m_new.ill = m_r[32];
          m_new.tag = tag_i;
          m_new.cnt = 1;
          mq.push_back(m_new);
        end
      end
    end
  end

  bit          c_mv;
  bit          p_stall = 1'b0;
  logic [37:0] p_out;
  always @(negedge clk_i) begin
    if (arst_ni) begin
      c_mv = (mq.size() > 0) && (mq[0].cnt == PS);
      chk("out_valid", 64'(out_valid_o), 64'(c_mv));
      chk("in_ready", 64'(in_ready_o), 64'(!c_mv || out_ready_i));
      if (c_mv) begin
        chk("result", 64'(result_o), 64'(mq[0].res));
        chk("tag", 64'(tag_o), 64'(mq[0].tag));
        chk("zero", 64'(zero_o), 64'(mq[0].res == 32'h0));
        chk("illegal", 64'(illegal_o), 64'(mq[0].ill));
      end
      if (p_stall && out_valid_o)
        chk("stall_hold", 64'({result_o, tag_o, zero_o, illegal_o}), 64'(p_out));
      if (out_valid_o && out_ready_i) tag_log.push_back(tag_o);
      p_stall = out_valid_o && !out_ready_i;
      p_out   = {result_o, tag_o, zero_o, illegal_o};
    end else begin
      p_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Holds the request until an edge where in_ready was high; returns just after that edge.
  task automatic drive(input logic [2:0] op, input logic ui, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [5:0] im, input logic [3:0] tg);
    bit acc;
    int n;
    op_i = op; use_imm_i = ui; rs1_data_i = r1; rs2_data_i = r2; imm_i = im; tag_i = tg;
    in_valid_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      acc = in_ready_o;
      @(posedge clk_i);
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
    #1 in_valid_i = 1'b0;
  endtask

  // Checks a single isolated op: not visible after one edge, visible after the second.
  task automatic lit(input string name, input logic [31:0] er, input logic ez, input logic ei, input logic [3:0] et);
    chk({name, "_lat1"}, 64'(out_valid_o), 64'(0));
    step();
    chk({name, "_valid"}, 64'(out_valid_o), 64'(1));
    chk({name, "_result"}, 64'(result_o), 64'(er));
    chk({name, "_zero"}, 64'(zero_o), 64'(ez));
    chk({name, "_illegal"}, 64'(illegal_o), 64'(ei));
    chk({name, "_tag"}, 64'(tag_o), 64'(et));
    step();
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        ui;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [5:0]  im;
  } vec_t;
  vec_t vt [13] = '{
    '{3'd0, 1'b0, 32'h1234_5678, 32'h0000_0000, 6'h00},
    '{3'd1, 1'b0, 32'h8765_4321, 32'h0000_0000, 6'h00},
    '{3'd2, 1'b1, 32'h8765_4321, 32'h0000_0000, 6'h00},
    '{3'd3, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 6'h00},
    '{3'd4, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 6'h08},
    '{3'd3, 1'b0, 32'h1234_5678, 32'h0000_0104, 6'h00},
    '{3'd2, 1'b0, 32'h8000_0000, 32'h0000_001F, 6'h00},
    '{3'd1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 6'h3F},
    '{3'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 6'h21},
    '{3'd6, 1'b0, 32'h0000_0001, 32'h0000_0001, 6'h00},
    '{3'd7, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 6'h01},
    '{3'd0, 1'b0, 32'hA5A5_0000, 32'hFFFF_FFF0, 6'h00},
    '{3'd2, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 6'h1E}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 arst_ni = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid_o), 64'(0));
    chk("rst_result", 64'(result_o), 64'(0));
    chk("rst_tag", 64'(tag_o), 64'(0));
    chk("rst_zero", 64'(zero_o), 64'(0));
    chk("rst_illegal", 64'(illegal_o), 64'(0));
    chk("rst_in_ready", 64'(in_ready_o), 64'(1));
    step();
    arst_ni = 1'b1;

    // Hand-computed single ops
    drive(3'd0, 1'b0, 32'h0000_0001, 32'd35, 6'h00, 4'd1);
    lit("sll35", 32'h0000_0008, 1'b0, 1'b0, 4'd1);
    drive(3'd2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd4, 4'd2);
    lit("sra4", 32'hF800_0000, 1'b0, 1'b0, 4'd2);
    drive(3'd1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd4, 4'd3);
    lit("srl4", 32'h0800_0000, 1'b0, 1'b0, 4'd3);
    drive(3'd3, 1'b1, 32'h8000_0001, 32'h0000_0000, 6'd1, 4'd4);
`ifdef ALU_SHIFT_ROTATE_EN
    lit("rol1", 32'h0000_0003, 1'b0, 1'b0, 4'd4);
`else
    lit("rol1", 32'h0000_0000, 1'b1, 1'b1, 4'd4);
`endif
    drive(3'd5, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 6'd7, 4'd5);
    lit("op101", 32'h0000_0000, 1'b1, 1'b1, 4'd5);

    // Back-to-back stream at full throughput
    foreach (vt[i]) drive(vt[i].op, vt[i].ui, vt[i].r1, vt[i].r2, vt[i].im, 4'(i));
    repeat (4) step();

    // Same stream under an irregular ready pattern
    fork
      foreach (vt[i]) drive(vt[i].op, vt[i].ui, vt[i].r1, vt[i].r2, vt[i].im, 4'(i + 3));
      for (int k = 0; k < 40; k++) begin
        out_ready_i = (k % 3 != 1) && (k % 7 != 5);
        step();
      end
    join
    out_ready_i = 1'b1;
    repeat (6) step();

    // Backpressure: three tags issued while the consumer stalls
    tag_log.delete();
    out_ready_i = 1'b0;
    fork
      begin
        drive(3'd0, 1'b1, 32'h0000_0011, 32'h0, 6'd1, 4'd1);
        drive(3'd1, 1'b1, 32'h0000_0022, 32'h0, 6'd1, 4'd2);
        drive(3'd2, 1'b1, 32'h8000_0033, 32'h0, 6'd1, 4'd3);
      end
      begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("bp_in_ready_low", 64'(in_ready_o), 64'(0));
        chk("bp_head_valid", 64'(out_valid_o), 64'(1));
        chk("bp_head_tag", 64'(tag_o), 64'(1));
        repeat (2) @(posedge clk_i);
        #1 out_ready_i = 1'b1;
      end
    join
    repeat (5) step();
    chk("bp_count", 64'(tag_log.size()), 64'(3));
    for (int i = 0; i < 3 && i < tag_log.size(); i++)
      chk("bp_order", 64'(tag_log[i]), 64'(i + 1));

    // Reset with two ops in flight
    drive(3'd0, 1'b1, 32'h0000_0F0F, 32'h0, 6'd2, 4'd4);
    drive(3'd1, 1'b1, 32'hF0F0_0000, 32'h0, 6'd2, 4'd5);
    arst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid_o), 64'(0));
    chk("mid_rst_result", 64'(result_o), 64'(0));
    chk("mid_rst_tag", 64'(tag_o), 64'(0));
    chk("mid_rst_zero", 64'(zero_o), 64'(0));
    chk("mid_rst_illegal", 64'(illegal_o), 64'(0));
    step();
    step();
    arst_ni = 1'b1;
    chk("post_rst_in_ready", 64'(in_ready_o), 64'(1));
    drive(3'd0, 1'b1, 32'hA5A5_A5A5, 32'h0, 6'd0, 4'd9);
    lit("post_rst_sll0", 32'hA5A5_A5A5, 1'b0, 1'b0, 4'd9);
    repeat (3) begin
      chk("no_stale", 64'(out_valid_o), 64'(0));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
